// File: rtl/sm_frame_accumulator.sv
// Frame accumulator for sign-magnitude samples: converts each accepted sample to
// two's complement, sums FRAME of them with saturation, then holds the total for the consumer.
module sm_frame_accumulator #(
  parameter int N     = 4,
  parameter int FRAME = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             out_nzero
);

  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Sign-magnitude to two's complement, one bit wider than the accumulator;
  // negative zero naturally maps to zero.
  function automatic logic [ACC_W:0] sm_to_tc(input logic [N-1:0] sm);
    logic [ACC_W:0] mag_v;
    mag_v = {{(ACC_W+2-N){1'b0}}, sm[N-2:0]};
    if (sm[N-1]) begin
      sm_to_tc = ~mag_v + {{ACC_W{1'b0}}, 1'b1};
    end else begin
      sm_to_tc = mag_v;
    end
  endfunction

  state_t           state_r, state_nx_s;
  logic [ACC_W-1:0] acc_r, acc_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             sat_r, sat_nx_s;
  logic             nz_r, nz_nx_s;
  logic             out_valid_r, out_valid_nx_s;
  logic             in_ready_r, in_ready_nx_s;

  logic [ACC_W:0]   value_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] sat_acc_s;
  logic             ovf_s;
  logic             neg_zero_s;
  logic             accept_s;

  assign in_ready  = in_ready_r & ~reset;
  assign out_valid = out_valid_r;
  assign out_acc   = acc_r;
  assign out_sat   = sat_r;
  assign out_nzero = nz_r;
  assign accept_s  = in_valid & in_ready;

  // Saturating add of the incoming sample; the sum cannot wrap in ACC_W+1 bits,
  // so the top two bits disagreeing means the result left the ACC_W range.
  always_comb begin
    value_s    = sm_to_tc(in_sum);
    sum_s      = {acc_r[ACC_W-1], acc_r} + value_s;
    neg_zero_s = in_sum[N-1] & (in_sum[N-2:0] == {(N-1){1'b0}});
    if (!sum_s[ACC_W] && sum_s[ACC_W-1]) begin
      sat_acc_s = ACC_MAX;
      ovf_s     = 1'b1;
    end else if (sum_s[ACC_W] && !sum_s[ACC_W-1]) begin
      sat_acc_s = ACC_MIN;
      ovf_s     = 1'b1;
    end else begin
      sat_acc_s = sum_s[ACC_W-1:0];
      ovf_s     = 1'b0;
    end
  end

  // Next-state and next-register logic for the accumulate/hold handshake.
  always_comb begin
    state_nx_s     = state_r;
    acc_nx_s       = acc_r;
    cnt_nx_s       = cnt_r;
    sat_nx_s       = sat_r;
    nz_nx_s        = nz_r;
    out_valid_nx_s = out_valid_r;
    in_ready_nx_s  = in_ready_r;
    case (state_r)
      ST_ACCUM: begin
        if (accept_s) begin
          acc_nx_s = sat_acc_s;
          cnt_nx_s = cnt_r + CNT_ONE;
          sat_nx_s = sat_r | ovf_s;
          nz_nx_s  = nz_r | neg_zero_s;
          if (cnt_r == LAST_CNT) begin
            state_nx_s     = ST_HOLD;
            out_valid_nx_s = 1'b1;
            in_ready_nx_s  = 1'b0;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) begin
          state_nx_s     = ST_ACCUM;
          acc_nx_s       = ACC_ZERO;
          cnt_nx_s       = CNT_ZERO;
          sat_nx_s       = 1'b0;
          nz_nx_s        = 1'b0;
          out_valid_nx_s = 1'b0;
          in_ready_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s     = ST_ACCUM;
        acc_nx_s       = ACC_ZERO;
        cnt_nx_s       = CNT_ZERO;
        sat_nx_s       = 1'b0;
        nz_nx_s        = 1'b0;
        out_valid_nx_s = 1'b0;
        in_ready_nx_s  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial or pending frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_ACCUM;
      acc_r       <= ACC_ZERO;
      cnt_r       <= CNT_ZERO;
      sat_r       <= 1'b0;
      nz_r        <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      acc_r       <= acc_nx_s;
      cnt_r       <= cnt_nx_s;
      sat_r       <= sat_nx_s;
      nz_r        <= nz_nx_s;
      out_valid_r <= out_valid_nx_s;
      in_ready_r  <= in_ready_nx_s;
    end
  end

endmodule

// File: tb/tb_sm_frame_accumulator.sv
// Bench: two accumulators (ACC_W=6 and ACC_W=4) share one stimulus stream and are
// checked every cycle against an integer frame model, plus hand-computed frame totals.
module tb_sm_frame_accumulator;

  localparam int N     = 4;
  localparam int FRAME = 4;
  localparam int AW_A  = 6;
  localparam int AW_B  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N-1:0]    in_sum = 4'b0000;
  logic            in_ready_a, out_valid_a, out_sat_a, out_nzero_a;
  logic            in_ready_b, out_valid_b, out_sat_b, out_nzero_b;
  logic [AW_A-1:0] out_acc_a;
  logic [AW_B-1:0] out_acc_b;

  int checks = 0;
  int errors = 0;

  sm_frame_accumulator #(.N(N), .FRAME(FRAME), .ACC_W(AW_A)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_sat(out_sat_a), .out_nzero(out_nzero_a));

  sm_frame_accumulator #(.N(N), .FRAME(FRAME), .ACC_W(AW_B)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_sat(out_sat_b), .out_nzero(out_nzero_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer running sums clamped to each width's range.
  int m_acc_a = 0, m_acc_b = 0, m_cnt = 0;
  bit m_hold = 1'b0, m_sat_a = 1'b0, m_sat_b = 1'b0, m_nz = 1'b0;

  function automatic int lim(input int v, input int w, output bit sat);
    int hi, lo;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    sat = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(posedge clk) begin : model
    int v;
    bit s;
    if (reset) begin
      m_hold = 1'b0; m_cnt = 0; m_acc_a = 0; m_acc_b = 0;
      m_sat_a = 1'b0; m_sat_b = 1'b0; m_nz = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0; m_cnt = 0; m_acc_a = 0; m_acc_b = 0;
        m_sat_a = 1'b0; m_sat_b = 1'b0; m_nz = 1'b0;
      end
    end else if (in_valid) begin
      v = int'(in_sum[2:0]);
      if (in_sum[3]) v = -v;
      if (in_sum == 4'b1000) m_nz = 1'b1;
      m_acc_a = lim(m_acc_a + v, AW_A, s); m_sat_a = m_sat_a | s;
      m_acc_b = lim(m_acc_b + v, AW_B, s); m_sat_b = m_sat_b | s;
      m_cnt++;
      if (m_cnt == FRAME) m_hold = 1'b1;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(posedge clk) begin
    #2;
    chk("in_ready_a", int'(in_ready_a), int'(!m_hold && !reset));
    chk("in_ready_b", int'(in_ready_b), int'(!m_hold && !reset));
    chk("out_valid_a", int'(out_valid_a), int'(m_hold));
    chk("out_valid_b", int'(out_valid_b), int'(m_hold));
    if (m_hold) begin
      chk("out_acc_a", int'($signed(out_acc_a)), m_acc_a);
      chk("out_acc_b", int'($signed(out_acc_b)), m_acc_b);
      chk("out_sat_a", int'(out_sat_a), int'(m_sat_a));
      chk("out_sat_b", int'(out_sat_b), int'(m_sat_b));
      chk("out_nzero_a", int'(out_nzero_a), int'(m_nz));
      chk("out_nzero_b", int'(out_nzero_b), int'(m_nz));
    end
  end

  task automatic send(input logic [N-1:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = s;
      #1;
      n++;
    end while (!in_ready_a && n < 50);
    if (!in_ready_a) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a frame result and pin it to hand-computed totals.
  task automatic expect_frame(input string tag, input int ea, input int esa,
                              input int eb, input int esb, input int enz);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, int'(out_valid_a), 1);
    chk({tag, "_acc_a"}, int'($signed(out_acc_a)), ea);
    chk({tag, "_sat_a"}, int'(out_sat_a), esa);
    chk({tag, "_acc_b"}, int'($signed(out_acc_b)), eb);
    chk({tag, "_sat_b"}, int'(out_sat_b), esb);
    chk({tag, "_nzero"}, int'(out_nzero_a), enz);
  endtask

  task automatic release_frame();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_acc", int'(out_acc_a), 0);
    chk("rst_flags", int'({out_sat_a, out_nzero_a}), 0);

    // Basic frame: 3 + 5 - 2 + 1
    send(4'b0011); send(4'b0101); send(4'b1010); send(4'b0001);
    expect_frame("basic", 7, 0, 6, 1, 0);
    release_frame();

    // Negative zero
    send(4'b1000); send(4'b0000); send(4'b1111); send(4'b0111);
    expect_frame("negzero", 0, 0, 0, 0, 1);
    release_frame();

    // Saturation in the narrow accumulator, then a clean frame
    send(4'b0111); send(4'b0111); send(4'b1111); send(4'b0011);
    expect_frame("sat", 10, 0, 3, 1, 0);
    release_frame();
    repeat (4) send(4'b0001);
    expect_frame("after_sat", 4, 0, 4, 0, 0);
    release_frame();

    // Backpressure: a valid sample waits through HOLD and becomes sample 1
    repeat (4) send(4'b0010);
    expect_frame("bp_first", 8, 0, 7, 1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 4'b0001;
    repeat (5) begin
      #1;
      chk("bp_in_ready", int'(in_ready_a), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_ready_again", int'(in_ready_a), 1);
    repeat (3) send(4'b0001);
    expect_frame("bp_second", 4, 0, 4, 0, 0);
    release_frame();

    // Bubbles: valid pattern 1,0,0,1,0,1,1
    send(4'b0001); idle(); idle(); send(4'b0001); idle(); send(4'b0001); send(4'b0001);
    expect_frame("bubbles", 4, 0, 4, 0, 0);
    release_frame();

    // Reset mid-frame, then reset during HOLD
    send(4'b0111); send(4'b0111);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) send(4'b0001);
    expect_frame("post_reset", 4, 0, 4, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("hold_reset_valid", int'(out_valid_a), 0);
    chk("hold_reset_ready", int'(in_ready_a), 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
